keypad_event_queue: RTL and testbench
=====================================

Name: keypad_event_queue

Overview:
- Downstream consumer of the keypad scanner's `press` / `keyOut` pair.
- Synchronizes and debounces the scanner output and emits exactly one event per physical key press.
- Buffers events in a small FIFO and presents them to the MCU as an interrupt-driven, memory-mapped input.
- The MCU reads the head key, then pulses `ack` to pop it.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable sampled cycles required to accept a press or a release. Legal range 2..65535.
- DEPTH, 4: FIFO entries. Must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- press  in  1  scanner "some column high" flag; asynchronous to the debounce logic.
- key_in  in  4  scanner key code. 0-11 are valid keys; 13 means no key.
- ack  in  1  MCU pop strobe; one pop per cycle high.
- clr_ovf  in  1  clears the sticky overflow flag.
- key_out  out  4  FIFO head code; 4'd13 when empty.
- valid  out  1  FIFO not empty.
- intr  out  1  interrupt request; equals `valid`.
- count  out  $clog2(DEPTH+1)  number of queued entries.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; debounce counter = 0.
  - Sync flops cleared; press samples as 0, key samples as 13.
  - FIFO emptied: count = 0, valid = 0, intr = 0, key_out = 13, overflow = 0.
- Synchronizer:
  - `press` and `key_in` each pass through 2 flops, giving `s_press` and `s_key`.
  - "Pressed" condition: s_press = 1 and s_key ≠ 13 and s_key ≤ 11.
- FSM states:
  - IDLE: if pressed, capture cand = s_key, set cnt = 1, go to PRESS_WAIT.
  - PRESS_WAIT:
    - If not pressed, or s_key ≠ cand: cnt = 0, go to IDLE.
    - Else if cnt = DEBOUNCE_CYCLES-1: push cand, go to HELD.
    - Else cnt++.
  - HELD: if not pressed, set cnt = 1 and go to REL_WAIT. A key-code change while still pressed is ignored; it is the same held press.
  - REL_WAIT:
    - If pressed: cnt = 0, go to HELD (bounce).
    - Else if cnt = DEBOUNCE_CYCLES-1: cnt = 0, go to IDLE.
    - Else cnt++.
- Push latency: `valid` rises exactly DEBOUNCE_CYCLES+3 clock edges after stable inputs are applied to an empty, idle block (2 sync edges + DEBOUNCE_CYCLES stable samples + 1 write edge).
- Exactly one push per press.
- A new press is only recognized after a full debounced release.
- FIFO rules:
  - Push when not full: write at the write pointer, wrp++, count++.
  - Push when full and no pop in the same cycle: data dropped, overflow ← 1.
  - Push and ack in the same cycle when full: both take effect; count is unchanged; no overflow.
  - Ack when empty: ignored; count stays 0.
  - Push and ack together when empty: push only; the new entry is visible next cycle.
  - Pointers wrap modulo DEPTH.
  - key_out is combinational from the head entry.
- overflow:
  - Set by a dropped push; cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, set wins.
- Reset mid-debounce or with a non-empty FIFO discards everything. After rst_n deasserts, a held key must complete a full debounce before it produces an event.

Decomposition:
- Package keypad_pkg:
  - NO_KEY = 4'd13, KEY_STAR = 4'd10, KEY_HASH = 4'd11.
  - Enum deb_state_t {IDLE, PRESS_WAIT, HELD, REL_WAIT}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push, pop, din, dout, count, full, empty; async active-low reset.
- Debounce FSM and synchronizer live in the top level.

Test Plan (DEBOUNCE_CYCLES=4, DEPTH=4):
- Clean press: press=1, key_in=5 held for 20 cycles, then released.
  - valid and intr rise exactly 7 edges later; key_out = 5; count = 1.
  - ack pulse → count = 0, key_out = 13.
- Bounce: press toggles 1,0,1,0 each cycle with key_in=7, then stays high.
  - No push during the toggling.
  - A single push of 7 occurs 7 edges after the last rising toggle.
  - Release bounces produce no second event.
- Fill and overflow: five debounced presses of keys 1,2,3,4,9 with no ack.
  - count = 4; overflow = 1; pops return 1,2,3,4 in order; key 9 is absent.
  - clr_ovf → overflow = 0.
- Simultaneous: FIFO full; ack asserted on the exact push cycle of key 0.
  - count stays 4; overflow stays 0; the tail entry is 0.
- Reset mid-operation: rst_n low during PRESS_WAIT with 2 entries queued.
  - All outputs go to reset values immediately, without waiting for a clock.
  - With the key still held after release of reset: one event after 7 edges.
- Edge codes: press=1 with key_in=13 or key_in=12 for 20 cycles → no push. Ack on empty → count stays 0.

Source files
------------

// File: rtl/keypad_event_queue_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad event queue: special key codes, the
// debounce FSM state encoding and a helper that classifies scanner codes.
// No ports; imported by keypad_event_queue.
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam logic [3:0] NO_KEY   = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } deb_state_t;

  // Only codes 0..11 correspond to physical keys; 12 is unused and 13 is
  // the scanner's "nothing pressed" marker.
  function automatic logic is_valid_key(input logic [3:0] code);
    return (code != NO_KEY) && (code <= KEY_HASH);
  endfunction

endpackage

// File: rtl/keypad_event_queue_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Small single-clock FIFO holding debounced key events.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    write strobe and data
//   pop          read strobe (ignored while empty)
//   dout         head entry (only meaningful when not empty)
//   count        number of stored entries
//   full, empty  occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrp;
  logic [AW-1:0]    rdp;
  logic             do_push;
  logic             do_pop;

  // Occupancy flags and the effective push/pop qualifiers. A pop frees a
  // slot in the same cycle, which is what lets a push into a full FIFO land.
  always_comb begin
    full    = (count == FULL_COUNT);
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rdp];
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wrp] <= din;
    end
  end

  // Pointers and occupancy count. Pointer width equals log2(DEPTH), so the
  // increment wraps modulo DEPTH without extra logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrp   <= '0;
      rdp   <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wrp <= wrp + AW'(1);
      end
      if (do_pop) begin
        rdp <= rdp + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_event_queue.sv
// -----------------------------------------------------------------------------
// keypad_event_queue
// Synchronizes and debounces the keypad scanner output, emits one event per
// physical press and queues events for the MCU.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   press        scanner "some column high" flag (asynchronous)
//   key_in       scanner key code (0..11 keys, 13 = no key)
//   ack          MCU pop strobe
//   clr_ovf      clears the sticky overflow flag
//   key_out      head key code, 13 when the queue is empty
//   valid, intr  queue not empty (intr mirrors valid)
//   count        queued entries
//   overflow     sticky flag: an event was dropped on a full queue
// -----------------------------------------------------------------------------
module keypad_event_queue
  import keypad_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       press,
  input  logic [3:0]                 key_in,
  input  logic                       ack,
  input  logic                       clr_ovf,
  output logic [3:0]                 key_out,
  output logic                       valid,
  output logic                       intr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam logic [15:0] LAST_CNT = DEBOUNCE_CYCLES - 16'd1;

  logic       press_meta;
  logic       s_press;
  logic [3:0] key_meta;
  logic [3:0] s_key;
  logic       pressed;

  deb_state_t state;
  logic [15:0] cnt;
  logic [3:0]  cand;
  logic        push_r;

  logic [3:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;

  // Two-flop synchronizer for the scanner outputs. Reset values make the
  // synchronized view look like "nothing pressed".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_meta <= 1'b0;
      s_press    <= 1'b0;
      key_meta   <= NO_KEY;
      s_key      <= NO_KEY;
    end else begin
      press_meta <= press;
      s_press    <= press_meta;
      key_meta   <= key_in;
      s_key      <= key_meta;
    end
  end

  assign pressed = s_press && is_valid_key(s_key);

  // Debounce FSM. A press must be seen with the same key code for
  // DEBOUNCE_CYCLES consecutive samples before it is pushed; the push strobe
  // is registered, so the FIFO write lands one edge after acceptance. After
  // a push the key must be released for DEBOUNCE_CYCLES consecutive samples
  // before another press can start, so contact bounce on release is absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 16'd0;
      cand   <= NO_KEY;
      push_r <= 1'b0;
    end else begin
      push_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pressed) begin
            cand  <= s_key;
            cnt   <= 16'd1;
            state <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!pressed || (s_key != cand)) begin
            cnt   <= 16'd0;
            state <= IDLE;
          end else if (cnt == LAST_CNT) begin
            push_r <= 1'b1;
            cnt    <= 16'd0;
            state  <= HELD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HELD: begin
          if (!pressed) begin
            cnt   <= 16'd1;
            state <= REL_WAIT;
          end
        end
        REL_WAIT: begin
          if (pressed) begin
            cnt   <= 16'd0;
            state <= HELD;
          end else if (cnt == LAST_CNT) begin
            cnt   <= 16'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          cnt   <= 16'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (4),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_r),
    .pop   (ack),
    .din   (cand),
    .dout  (fifo_dout),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow. An event is only lost when the queue is full and the
  // MCU is not popping in that same cycle; a drop outranks a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_r && fifo_full && !ack) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // MCU-facing view of the queue head.
  always_comb begin
    valid   = !fifo_empty;
    intr    = !fifo_empty;
    key_out = fifo_empty ? NO_KEY : fifo_dout;
  end

endmodule

// File: tb/tb_keypad_event_queue.sv
// -----------------------------------------------------------------------------
// tb_keypad_event_queue
// Directed bench for keypad_event_queue with DEBOUNCE_CYCLES=4, DEPTH=4.
// Inputs change on the falling clock edge and outputs are sampled on the
// falling edge, half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_keypad_event_queue;

  logic       clk;
  logic       rst_n;
  logic       press;
  logic [3:0] key_in;
  logic       ack;
  logic       clr_ovf;
  logic [3:0] key_out;
  logic       valid;
  logic       intr;
  logic [2:0] count;
  logic       overflow;

  int vectors;
  int miscompares;

  keypad_event_queue #(
    .DEBOUNCE_CYCLES (16'd4),
    .DEPTH           (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .press    (press),
    .key_in   (key_in),
    .ack      (ack),
    .clr_ovf  (clr_ovf),
    .key_out  (key_out),
    .valid    (valid),
    .intr     (intr),
    .count    (count),
    .overflow (overflow)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts falling edges until valid is first seen high, up to 20 edges;
  // returns 0 if valid never rose. Inputs are left untouched.
  task automatic measure_rise(output int rise);
    rise = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (valid && rise == 0) rise = e;
    end
  endtask

  // One clean press of key k held 10 cycles, then 10 cycles of release.
  task automatic press_key(input logic [3:0] k);
    press  = 1'b1;
    key_in = k;
    repeat (10) @(negedge clk);
    press  = 1'b0;
    key_in = 4'd13;
    repeat (10) @(negedge clk);
  endtask

  // Single-cycle ack pulse.
  task automatic pop_one();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Outputs must show reset values while rst_n is held low before any edge.
  task automatic test_reset();
    rst_n   = 1'b0;
    press   = 1'b0;
    key_in  = 4'd13;
    ack     = 1'b0;
    clr_ovf = 1'b0;
    #2;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got=%0d exp=0", valid); end
    vectors++; if (intr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_intr got=%0d exp=0", intr); end
    vectors++; if (key_out !== 4'd13) begin miscompares++; $display("[TB] FAIL reset_key_out got=%0d exp=13", key_out); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow got=%0d exp=0", overflow); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Clean press of key 5: valid rises on edge 7, then one ack empties it.
  task automatic test_clean_press();
    int rise;
    press  = 1'b1;
    key_in = 4'd5;
    measure_rise(rise);
    vectors++; if (rise !== 7) begin miscompares++; $display("[TB] FAIL clean_latency got=%0d exp=7", rise); end
    vectors++; if (key_out !== 4'd5) begin miscompares++; $display("[TB] FAIL clean_key_out got=%0d exp=5", key_out); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("[TB] FAIL clean_count got=%0d exp=1", count); end
    vectors++; if (intr !== 1'b1) begin miscompares++; $display("[TB] FAIL clean_intr got=%0d exp=1", intr); end
    press  = 1'b0;
    key_in = 4'd13;
    repeat (10) @(negedge clk);
    vectors++; if (count !== 3'd1) begin miscompares++; $display("[TB] FAIL clean_release_count got=%0d exp=1", count); end
    pop_one();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL clean_pop_count got=%0d exp=0", count); end
    vectors++; if (key_out !== 4'd13) begin miscompares++; $display("[TB] FAIL clean_pop_key_out got=%0d exp=13", key_out); end
    vectors++; if (intr !== 1'b0) begin miscompares++; $display("[TB] FAIL clean_pop_intr got=%0d exp=0", intr); end
  endtask

  // Press bounces 1,0,1,0 then settles high; release bounces likewise.
  task automatic test_bounce();
    int rise;
    key_in = 4'd7;
    for (int i = 0; i < 4; i++) begin
      press = (i % 2 == 0);
      @(negedge clk);
    end
    press = 1'b1;
    measure_rise(rise);
    vectors++; if (rise !== 7) begin miscompares++; $display("[TB] FAIL bounce_latency got=%0d exp=7", rise); end
    vectors++; if (key_out !== 4'd7) begin miscompares++; $display("[TB] FAIL bounce_key_out got=%0d exp=7", key_out); end
    for (int i = 0; i < 5; i++) begin
      press = (i % 2 == 1);
      @(negedge clk);
    end
    press  = 1'b0;
    key_in = 4'd13;
    repeat (15) @(negedge clk);
    vectors++; if (count !== 3'd1) begin miscompares++; $display("[TB] FAIL bounce_single_event got=%0d exp=1", count); end
    pop_one();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL bounce_pop_count got=%0d exp=0", count); end
  endtask

  // Five presses into a 4-deep queue: the fifth is dropped and flagged.
  task automatic test_fill_overflow();
    logic [3:0] exp_keys [4];
    exp_keys[0] = 4'd1;
    exp_keys[1] = 4'd2;
    exp_keys[2] = 4'd3;
    exp_keys[3] = 4'd4;
    press_key(4'd1);
    press_key(4'd2);
    press_key(4'd3);
    press_key(4'd4);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_no_overflow_yet got=%0d exp=0", overflow); end
    press_key(4'd9);
    vectors++; if (count !== 3'd4) begin miscompares++; $display("[TB] FAIL fill_count got=%0d exp=4", count); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_overflow got=%0d exp=1", overflow); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (key_out !== exp_keys[i]) begin miscompares++; $display("[TB] FAIL fill_pop_order[%0d] got=%0d exp=%0d", i, key_out, exp_keys[i]); end
      pop_one();
    end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL fill_drained_count got=%0d exp=0", count); end
    vectors++; if (key_out !== 4'd13) begin miscompares++; $display("[TB] FAIL fill_drained_key_out got=%0d exp=13", key_out); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_overflow_sticky got=%0d exp=1", overflow); end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_clr_ovf got=%0d exp=0", overflow); end
  endtask

  // Queue full; ack lands on the same edge as the push of key 0.
  task automatic test_simultaneous();
    press_key(4'd1);
    press_key(4'd2);
    press_key(4'd3);
    press_key(4'd4);
    vectors++; if (count !== 3'd4) begin miscompares++; $display("[TB] FAIL simul_prefill_count got=%0d exp=4", count); end
    press  = 1'b1;
    key_in = 4'd0;
    repeat (6) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    vectors++; if (count !== 3'd4) begin miscompares++; $display("[TB] FAIL simul_count got=%0d exp=4", count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_overflow got=%0d exp=0", overflow); end
    vectors++; if (key_out !== 4'd2) begin miscompares++; $display("[TB] FAIL simul_head got=%0d exp=2", key_out); end
    repeat (3) @(negedge clk);
    press  = 1'b0;
    key_in = 4'd13;
    repeat (10) @(negedge clk);
    pop_one();
    pop_one();
    pop_one();
    vectors++; if (key_out !== 4'd0) begin miscompares++; $display("[TB] FAIL simul_tail got=%0d exp=0", key_out); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("[TB] FAIL simul_tail_count got=%0d exp=1", count); end
    pop_one();
  endtask

  // Reset asserted mid-debounce with two entries queued.
  task automatic test_reset_mid();
    int rise;
    press_key(4'd5);
    press_key(4'd6);
    press  = 1'b1;
    key_in = 4'd8;
    repeat (4) @(negedge clk);
    vectors++; if (count !== 3'd2) begin miscompares++; $display("[TB] FAIL rstmid_precount got=%0d exp=2", count); end
    rst_n = 1'b0;
    #1;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL rstmid_count got=%0d exp=0", count); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_valid got=%0d exp=0", valid); end
    vectors++; if (key_out !== 4'd13) begin miscompares++; $display("[TB] FAIL rstmid_key_out got=%0d exp=13", key_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    measure_rise(rise);
    vectors++; if (rise !== 7) begin miscompares++; $display("[TB] FAIL rstmid_latency got=%0d exp=7", rise); end
    vectors++; if (key_out !== 4'd8) begin miscompares++; $display("[TB] FAIL rstmid_key_out_after got=%0d exp=8", key_out); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("[TB] FAIL rstmid_count_after got=%0d exp=1", count); end
    press  = 1'b0;
    key_in = 4'd13;
    repeat (10) @(negedge clk);
    pop_one();
  endtask

  // Non-key codes, ack on empty, and push+ack together on an empty queue.
  task automatic test_edge_codes();
    press  = 1'b1;
    key_in = 4'd13;
    repeat (20) @(negedge clk);
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL edge_code13 got=%0d exp=0", count); end
    key_in = 4'd12;
    repeat (20) @(negedge clk);
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL edge_code12 got=%0d exp=0", count); end
    press  = 1'b0;
    key_in = 4'd13;
    repeat (10) @(negedge clk);
    pop_one();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL edge_ack_empty_count got=%0d exp=0", count); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_ack_empty_valid got=%0d exp=0", valid); end
    press  = 1'b1;
    key_in = 4'd11;
    repeat (6) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    vectors++; if (count !== 3'd1) begin miscompares++; $display("[TB] FAIL edge_push_ack_empty_count got=%0d exp=1", count); end
    vectors++; if (key_out !== 4'd11) begin miscompares++; $display("[TB] FAIL edge_push_ack_empty_key got=%0d exp=11", key_out); end
    press  = 1'b0;
    key_in = 4'd13;
    repeat (10) @(negedge clk);
    pop_one();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL edge_final_count got=%0d exp=0", count); end
  endtask

  // Scenario sequence and summary.
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_fill_overflow();
    test_simultaneous();
    test_reset_mid();
    test_edge_codes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
